// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two
// valid/ready requesters, with a one-entry registered response slot per port.

`ifndef RF_XLEN
`define RF_XLEN 32
`endif
`ifndef ALU_OPSLEN
`define ALU_OPSLEN 4
`endif
`ifndef ALU_OPS_ADD
`define ALU_OPS_ADD  4'd0
`define ALU_OPS_SUB  4'd1
`define ALU_OPS_SLL  4'd2
`define ALU_OPS_SLT  4'd3
`define ALU_OPS_SLTU 4'd4
`define ALU_OPS_XOR  4'd5
`define ALU_OPS_SRL  4'd6
`define ALU_OPS_SRA  4'd7
`define ALU_OPS_OR   4'd8
`define ALU_OPS_AND  4'd9
`define ALU_OPS_JALR 4'd10
`endif

module alu_arbiter #(
  parameter int unsigned XLEN  = `RF_XLEN,
  parameter int unsigned OPLEN = `ALU_OPSLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [OPLEN-1:0] req0_op_i,
  input  logic [XLEN-1:0]  req0_a_i,
  input  logic [XLEN-1:0]  req0_b_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [OPLEN-1:0] req1_op_i,
  input  logic [XLEN-1:0]  req1_a_i,
  input  logic [XLEN-1:0]  req1_b_i,
  output logic             rsp0_valid_o,
  input  logic             rsp0_ready_i,
  output logic [XLEN-1:0]  rsp0_data_o,
  output logic             rsp1_valid_o,
  input  logic             rsp1_ready_i,
  output logic [XLEN-1:0]  rsp1_data_o
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic             prio_q, prio_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]  rsp_data0_q, rsp_data0_d;
  logic [XLEN-1:0]  rsp_data1_q, rsp_data1_d;

  logic             free0_c, free1_c, elig0_c, elig1_c, fire0_c, fire1_c;
  logic [OPLEN-1:0] alu_op_c;
  logic [XLEN-1:0]  alu_a_c, alu_b_c, alu_sum_c, alu_res_c;

  // A slot that drains this cycle can accept a new result on the same edge.
  assign free0_c = !rsp_valid_q[0] | rsp0_ready_i;
  assign free1_c = !rsp_valid_q[1] | rsp1_ready_i;
  assign elig0_c = req0_valid_i & free0_c;
  assign elig1_c = req1_valid_i & free1_c;

  // Ready never looks at the port's own valid, so at most one handshake fires.
  assign req0_ready_o = free0_c & (!prio_q | !elig1_c);
  assign req1_ready_o = free1_c & ( prio_q | !elig0_c);
  assign fire0_c      = req0_valid_i & req0_ready_o;
  assign fire1_c      = req1_valid_i & req1_ready_o;

  // Operand mux: the firing port, otherwise the priority holder (result unused).
  always_comb begin
    alu_op_c = req0_op_i;
    alu_a_c  = req0_a_i;
    alu_b_c  = req0_b_i;
    if (fire1_c || (!fire0_c && prio_q)) begin
      alu_op_c = req1_op_i;
      alu_a_c  = req1_a_i;
      alu_b_c  = req1_b_i;
    end
  end

  // Shared combinational ALU.
  always_comb begin
    alu_sum_c = alu_a_c + alu_b_c;
    alu_res_c = '0;
    case (alu_op_c)
      `ALU_OPS_ADD:  alu_res_c = alu_sum_c;
      `ALU_OPS_SUB:  alu_res_c = alu_a_c - alu_b_c;
      `ALU_OPS_SLL:  alu_res_c = alu_a_c << alu_b_c[SHW-1:0];
      `ALU_OPS_SLT:  alu_res_c = XLEN'($signed(alu_a_c) < $signed(alu_b_c));
      `ALU_OPS_SLTU: alu_res_c = XLEN'(alu_a_c < alu_b_c);
      `ALU_OPS_XOR:  alu_res_c = alu_a_c ^ alu_b_c;
      `ALU_OPS_SRL:  alu_res_c = alu_a_c >> alu_b_c[SHW-1:0];
      `ALU_OPS_SRA:  alu_res_c = XLEN'($signed(alu_a_c) >>> alu_b_c[SHW-1:0]);
      `ALU_OPS_OR:   alu_res_c = alu_a_c | alu_b_c;
      `ALU_OPS_AND:  alu_res_c = alu_a_c & alu_b_c;
      `ALU_OPS_JALR: alu_res_c = {alu_sum_c[XLEN-1:1], 1'b0};
      default:       alu_res_c = '0;
    endcase
  end

  // Next state: drain, then capture (capture wins so drain+accept has no bubble).
  always_comb begin
    prio_d      = prio_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data0_d = rsp_data0_q;
    rsp_data1_d = rsp_data1_q;
    if (rsp_valid_q[0] && rsp0_ready_i) rsp_valid_d[0] = 1'b0;
    if (rsp_valid_q[1] && rsp1_ready_i) rsp_valid_d[1] = 1'b0;
    if (fire0_c) begin
      rsp_valid_d[0] = 1'b1;
      rsp_data0_d    = alu_res_c;
      prio_d         = 1'b1;
    end
    if (fire1_c) begin
      rsp_valid_d[1] = 1'b1;
      rsp_data1_d    = alu_res_c;
      prio_d         = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q      <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_data0_q <= '0;
      rsp_data1_q <= '0;
    end else begin
      prio_q      <= prio_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data0_q <= rsp_data0_d;
      rsp_data1_q <= rsp_data1_d;
    end
  end

  assign rsp0_valid_o = rsp_valid_q[0];
  assign rsp1_valid_o = rsp_valid_q[1];
  assign rsp0_data_o  = rsp_data0_q;
  assign rsp1_data_o  = rsp_data1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors with a per-port expected-response scoreboard.

module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_JALR = 4'd10;

  logic        clk, rst_n;
  logic        req0_valid_i, req0_ready_o, req1_valid_i, req1_ready_o;
  logic [3:0]  req0_op_i, req1_op_i;
  logic [31:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
  logic        rsp0_valid_o, rsp0_ready_i, rsp1_valid_o, rsp1_ready_i;
  logic [31:0] rsp0_data_o, rsp1_data_o;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] exp0, exp1;
  logic        f0, f1;

  alu_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid_i (req0_valid_i),
    .req0_ready_o (req0_ready_o),
    .req0_op_i    (req0_op_i),
    .req0_a_i     (req0_a_i),
    .req0_b_i     (req0_b_i),
    .req1_valid_i (req1_valid_i),
    .req1_ready_o (req1_ready_o),
    .req1_op_i    (req1_op_i),
    .req1_a_i     (req1_a_i),
    .req1_b_i     (req1_b_i),
    .rsp0_valid_o (rsp0_valid_o),
    .rsp0_ready_i (rsp0_ready_i),
    .rsp0_data_o  (rsp0_data_o),
    .rsp1_valid_o (rsp1_valid_o),
    .rsp1_ready_i (rsp1_ready_i),
    .rsp1_data_o  (rsp1_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: a non-empty queue means the slot must be presenting its head.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (q0.size() == 0) chk("rsp0_valid_idle", 32'(rsp0_valid_o), 32'd0);
        else begin
          chk("rsp0_valid", 32'(rsp0_valid_o), 32'd1);
          chk("rsp0_data", rsp0_data_o, q0[0]);
          if (rsp0_valid_o && rsp0_ready_i) void'(q0.pop_front());
        end
        if (q1.size() == 0) chk("rsp1_valid_idle", 32'(rsp1_valid_o), 32'd0);
        else begin
          chk("rsp1_valid", 32'(rsp1_valid_o), 32'd1);
          chk("rsp1_data", rsp1_data_o, q1[0]);
          if (rsp1_valid_o && rsp1_ready_i) void'(q1.pop_front());
        end
      end
    end
  endtask

  // One cycle: record handshakes mid-cycle, push expectations, return after next edge.
  task automatic tick();
    @(negedge clk);
    #1;
    f0 = req0_valid_i & req0_ready_o;
    f1 = req1_valid_i & req1_ready_o;
    chk("one_handshake", 32'(f0 & f1), 32'd0);
    if (rst_n) begin
      if (f0) q0.push_back(exp0);
      if (f1) q1.push_back(exp1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e);
    req0_op_i = op; req0_a_i = a; req0_b_i = b; exp0 = e; req0_valid_i = 1'b1;
  endtask

  task automatic set1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e);
    req1_op_i = op; req1_a_i = a; req1_b_i = b; exp1 = e; req1_valid_i = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid_i = 1'b0; req0_op_i = '0; req0_a_i = '0; req0_b_i = '0;
    req1_valid_i = 1'b0; req1_op_i = '0; req1_a_i = '0; req1_b_i = '0;
    rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
    exp0 = '0; exp1 = '0; f0 = 1'b0; f1 = 1'b0;
    fork
      monitor();
    join_none

    #2;
    chk("rst_rsp0_valid", 32'(rsp0_valid_o), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid_o), 32'd0);
    chk("rst_rsp0_data", rsp0_data_o, 32'd0);
    chk("rst_rsp1_data", rsp1_data_o, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rdy0_after_rst", 32'(req0_ready_o), 32'd1);
    chk("rdy1_after_rst_idle", 32'(req1_ready_o), 32'd1);

    // Contention straight after reset: port 0 first, then port 1, then alternation.
    rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
    set0(OP_SUB, 32'd10, 32'd3, 32'd7);
    set1(OP_XOR, 32'hF0, 32'h0F, 32'hFF);
    #1;
    chk("rdy0_contend", 32'(req0_ready_o), 32'd1);
    chk("rdy1_contend", 32'(req1_ready_o), 32'd0);
    tick();
    chk("contend_c0_g0", 32'(f0), 32'd1);
    chk("contend_c0_g1", 32'(f1), 32'd0);
    req0_valid_i = 1'b0;
    tick();
    chk("contend_c1_g1", 32'(f1), 32'd1);
    set0(OP_ADD, 32'd1, 32'd2, 32'd3);
    set1(OP_ADD, 32'd3, 32'd4, 32'd7);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("alt_g0", 32'(f0), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("alt_g1", 32'(f1), (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    repeat (2) tick();

    // Single op: ADD 5+7 -> 12 next cycle, deasserting the cycle after.
    set0(OP_ADD, 32'd5, 32'd7, 32'd12);
    #1 chk("single_rdy0", 32'(req0_ready_o), 32'd1);
    tick();
    chk("single_g0", 32'(f0), 32'd1);
    req0_valid_i = 1'b0;
    repeat (2) tick();

    // Backpressure isolation: port 0 stalled, port 1 streams JALR.
    rsp0_ready_i = 1'b0;
    set0(OP_ADD, 32'd9, 32'd9, 32'd18);
    tick();
    chk("bp_fill_g0", 32'(f0), 32'd1);
    set0(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    set1(OP_JALR, 32'h1001, 32'h4, 32'h1004);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_g0_blocked", 32'(f0), 32'd0);
      chk("bp_g1_stream", 32'(f1), 32'd1);
    end
    rsp0_ready_i = 1'b1;
    tick();
    chk("bp_release_g0", 32'(f0), 32'd1);
    chk("bp_release_g1", 32'(f1), 32'd0);
    req0_valid_i = 1'b0;
    tick();
    chk("bp_after_g1", 32'(f1), 32'd1);
    req1_valid_i = 1'b0;
    repeat (2) tick();

    // Drain and accept in the same cycle: 12 then 0x33 with no gap.
    rsp0_ready_i = 1'b0;
    set0(OP_ADD, 32'd5, 32'd7, 32'd12);
    tick();
    chk("da_fill_g0", 32'(f0), 32'd1);
    rsp0_ready_i = 1'b1;
    set0(OP_OR, 32'h30, 32'h03, 32'h33);
    tick();
    chk("da_accept_g0", 32'(f0), 32'd1);
    chk("da_valid_held", 32'(rsp0_valid_o), 32'd1);
    chk("da_new_data", rsp0_data_o, 32'h33);
    req0_valid_i = 1'b0;
    repeat (2) tick();

    // Reset mid-operation with both slots full.
    rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
    set0(OP_ADD, 32'd5, 32'd7, 32'd12);
    set1(OP_XOR, 32'hF0, 32'h0F, 32'hFF);
    repeat (2) tick();
    chk("mid_full0", 32'(rsp0_valid_o), 32'd1);
    chk("mid_full1", 32'(rsp1_valid_o), 32'd1);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    q0.delete(); q1.delete();
    #1;
    chk("mid_rst_valid0", 32'(rsp0_valid_o), 32'd0);
    chk("mid_rst_valid1", 32'(rsp1_valid_o), 32'd0);
    chk("mid_rst_data0", rsp0_data_o, 32'd0);
    chk("mid_rst_data1", rsp1_data_o, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rsp1_ready_i = 1'b1;
    set0(OP_ADD, 32'd1, 32'd1, 32'd2);
    set1(OP_ADD, 32'd3, 32'd4, 32'd7);
    #1 chk("post_rst_prio0", 32'(req1_ready_o), 32'd0);
    req0_valid_i = 1'b0;
    #1 chk("post_rst_rdy1_alone", 32'(req1_ready_o), 32'd1);
    tick();
    chk("post_rst_g1", 32'(f1), 32'd1);
    req1_valid_i = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
